// File: rtl/led7seg_595_frame_receiver_pkg.sv
// Shared definitions for the 74HC595 LED7-seg link: default geometry,
// derived frame/image widths and the receiver state encoding.
// Optional feature macro used by the receiver: LED7SEG_RX_TIMEOUT_EN.
package led7seg_pkg;

    localparam int DIG_NUM_DEF   = 8;
    localparam int SEG_NUM_DEF   = 8;
    localparam int CHA_WIDTH_DEF = DIG_NUM_DEF + SEG_NUM_DEF;
    localparam int DAT_WIDTH_DEF = DIG_NUM_DEF * SEG_NUM_DEF;

    typedef enum logic [1:0] {
        RX_IDLE    = 2'd0,
        RX_SHIFT   = 2'd1,
        RX_LATCH   = 2'd2,
        RX_PUBLISH = 2'd3
    } rx_state_e;

endpackage

// File: rtl/led7seg_595_frame_receiver_if.sv
// Serial pins plus published image of the LED7-seg frame receiver.
// Handshake: the pins carry no handshake (sampled asynchronously); on the
// output side vld is a 1-clk strobe meaning dat has just been updated, with
// no ready/back-pressure - a consumer must take dat while vld is high or
// read the held value later. frm_err is a 1-clk strobe, never with vld.
interface led7seg_595_frame_receiver_if
    import led7seg_pkg::*;
#(
    parameter int W = DAT_WIDTH_DEF
);
    logic         sclk;
    logic         rclk;
    logic         dio;
    logic [W-1:0] dat;
    logic         vld;
    logic         frm_err;

    // Transmit side: drives the pins, observes the receiver outputs.
    modport master (output sclk, output rclk, output dio,
                    input  dat,  input  vld,  input  frm_err);

    // Receive side: samples the pins, drives the image and strobes.
    modport slave  (input  sclk, input  rclk, input  dio,
                    output dat,  output vld,  output frm_err);
endinterface

// File: rtl/led7seg_595_frame_receiver_pin_sync_rise.sv
// Two-flop synchroniser for an asynchronous pin plus rising-edge detect.
// level_o is the synchronised level; rise_o is high for one clk, two clk
// after the pin rises, so the consumer's registers act on the third edge.
module pin_sync_rise (
    input  logic clk,
    input  logic rst,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o
);
    logic [2:0] sync_q;

    // Shift the pin through two sync stages and one history stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], pin_i};
        end
    end

    assign level_o = sync_q[1];
    assign rise_o  = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/led7seg_595_frame_receiver.sv
// Receive end of the 74HC595 LED7-seg link. Deserialises CHA_WIDTH-bit
// frames (segments above a one-hot digit select), rebuilds the full image
// one digit per frame and publishes it once every digit has been seen.
// Macro LED7SEG_RX_TIMEOUT_EN enables an idle timeout on partial frames.
module led7seg_595_frame_receiver
    import led7seg_pkg::*;
#(
    parameter int DIG_NUM  = DIG_NUM_DEF,
    parameter int SEG_NUM  = SEG_NUM_DEF,
    parameter int TO_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    led7seg_595_frame_receiver_if.slave   rx_if,
    output rx_state_e                     state_o
);
    localparam int CHA_WIDTH = DIG_NUM + SEG_NUM;
    localparam int DAT_WIDTH = DIG_NUM * SEG_NUM;
    localparam int CNT_W     = $clog2(CHA_WIDTH + 2);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CHA_WIDTH + 1);

    logic sclk_rise, rclk_rise, dio_lvl;
    logic sclk_lvl, rclk_lvl;

    rx_state_e              state_q, state_d;
    logic [CHA_WIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DIG_NUM-1:0]     mask_q, mask_d;
    logic [DAT_WIDTH-1:0]   image_q, image_d;
    logic [DAT_WIDTH-1:0]   dat_q, dat_d;
    logic                   frm_err_q, frm_err_d;
    logic                   timeout;

    logic [DIG_NUM-1:0]     sel;
    logic [SEG_NUM-1:0]     seg;
    logic                   frame_ok;

    pin_sync_rise u_sclk (.clk(clk), .rst(rst), .pin_i(rx_if.sclk),
                          .level_o(sclk_lvl), .rise_o(sclk_rise));
    pin_sync_rise u_rclk (.clk(clk), .rst(rst), .pin_i(rx_if.rclk),
                          .level_o(rclk_lvl), .rise_o(rclk_rise));
    pin_sync_rise u_dio  (.clk(clk), .rst(rst), .pin_i(rx_if.dio),
                          .level_o(dio_lvl),  .rise_o());

`ifdef LED7SEG_RX_TIMEOUT_EN
    logic [TO_WIDTH-1:0] to_cnt_q, to_cnt_d;
    logic                shift_quiet;

    // Count idle clk inside a partial frame; any pin edge restarts it.
    always_comb begin
        shift_quiet = (state_q == RX_SHIFT) && !sclk_rise && !rclk_rise;
        to_cnt_d    = '0;
        if (shift_quiet) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
        timeout = shift_quiet && (&to_cnt_q);
    end

    // Idle-timeout counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // The latch decision always uses registered (post-shift) contents, so a
    // shift landing in the same clk as the rclk edge is already included.
    assign sel      = shreg_q[DIG_NUM-1:0];
    assign seg      = shreg_q[CHA_WIDTH-1:DIG_NUM];
    assign frame_ok = (bit_cnt_q == CNT_FULL) && ($countones(sel) == 1);

    // Next-state, shifter, image assembly and publish decisions.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        mask_d    = mask_q;
        image_d   = image_q;
        dat_d     = dat_q;
        frm_err_d = 1'b0;

        if (sclk_rise) begin
            shreg_d = {shreg_q[CHA_WIDTH-2:0], dio_lvl};
            if (bit_cnt_q != CNT_SAT) begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end

        case (state_q)
            RX_IDLE: begin
                if (rclk_rise) begin
                    state_d = RX_LATCH;
                end else if (sclk_rise) begin
                    state_d = RX_SHIFT;
                end
            end
            RX_SHIFT: begin
                if (rclk_rise) begin
                    state_d = RX_LATCH;
                end else if (timeout) begin
                    frm_err_d = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = RX_IDLE;
                end
            end
            RX_LATCH: begin
                // A new shift may already be arriving; keep it as bit one.
                bit_cnt_d = {{(CNT_W-1){1'b0}}, sclk_rise};
                state_d   = sclk_rise ? RX_SHIFT : RX_IDLE;
                if (frame_ok) begin
                    for (int i = 0; i < DIG_NUM; i++) begin
                        if (sel[i]) begin
                            image_d[i*SEG_NUM +: SEG_NUM] = seg;
                        end
                    end
                    mask_d = mask_q | sel;
                    if (&mask_d) begin
                        dat_d   = image_d;
                        state_d = RX_PUBLISH;
                    end
                end else begin
                    frm_err_d = 1'b1;
                end
            end
            RX_PUBLISH: begin
                mask_d  = '0;
                state_d = (bit_cnt_q != '0) ? RX_SHIFT : RX_IDLE;
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= RX_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            mask_q    <= '0;
            image_q   <= '0;
            dat_q     <= '0;
            frm_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            mask_q    <= mask_d;
            image_q   <= image_d;
            dat_q     <= dat_d;
            frm_err_q <= frm_err_d;
        end
    end

    assign rx_if.dat     = dat_q;
    assign rx_if.vld     = (state_q == RX_PUBLISH);
    assign rx_if.frm_err = frm_err_q;
    assign state_o       = state_q;
endmodule

// File: tb/tb_led7seg_595_frame_receiver.sv
// Directed bench for the LED7-seg frame receiver: reset, full images,
// short and bad-select frames, overwrite + same-cycle edge, idle timeout.
module tb_led7seg_595_frame_receiver;
    import led7seg_pkg::*;

    logic      clk;
    logic      rst;
    rx_state_e state;
    int        n_checks;
    int        n_fail;

    led7seg_595_frame_receiver_if rx_if ();

    led7seg_595_frame_receiver #(
        .DIG_NUM (8),
        .SEG_NUM (8),
        .TO_WIDTH(4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .rx_if  (rx_if),
        .state_o(state)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Driver tasks (all called right after a falling clk edge)
    task automatic send_bit(input logic b);
        rx_if.dio = b;
        repeat (2) @(negedge clk);
        rx_if.sclk = 1'b1;
        repeat (2) @(negedge clk);
        rx_if.sclk = 1'b0;
    endtask

    task automatic send_bits(input logic [15:0] word, input int n);
        for (int i = 15; i > 15 - n; i--) send_bit(word[i]);
    endtask

    task automatic send_frame(input logic [7:0] seg, input int digit);
        logic [7:0] sel;
        sel = 8'b1 << digit;
        send_bits({seg, sel}, 16);
    endtask

    // rclk rise; vld/frm_err are due exactly 4 clk later, for one clk.
    task automatic latch(input logic exp_vld, input logic exp_err,
                         input logic with_sclk, input string tag);
        rx_if.rclk = 1'b1;
        if (with_sclk) rx_if.sclk = 1'b1;
        repeat (3) @(negedge clk);
        check({tag, "_vld_early"}, 64'(rx_if.vld), 64'(1'b0));
        check({tag, "_err_early"}, 64'(rx_if.frm_err), 64'(1'b0));
        @(negedge clk);
        check({tag, "_vld"}, 64'(rx_if.vld), 64'(exp_vld));
        check({tag, "_err"}, 64'(rx_if.frm_err), 64'(exp_err));
        @(negedge clk);
        check({tag, "_vld_after"}, 64'(rx_if.vld), 64'(1'b0));
        check({tag, "_err_after"}, 64'(rx_if.frm_err), 64'(1'b0));
        rx_if.rclk = 1'b0;
        rx_if.sclk = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int         err_pulses;
        logic [7:0] lb [8];

        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b0;
        rx_if.sclk = 1'b0;
        rx_if.rclk = 1'b0;
        rx_if.dio  = 1'b0;

        // 1: reset with pins toggling, then quiet after release
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rx_if.sclk = ~rx_if.sclk;
            rx_if.rclk = i[1];
            rx_if.dio  = i[0];
        end
        @(negedge clk);
        rx_if.sclk = 1'b0;
        rx_if.rclk = 1'b0;
        rx_if.dio  = 1'b0;
        check("rst_dat", rx_if.dat, 64'h0);
        check("rst_vld", 64'(rx_if.vld), 64'h0);
        check("rst_err", 64'(rx_if.frm_err), 64'h0);
        check("rst_state", 64'(state), 64'(RX_IDLE));
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("idle_vld", 64'(rx_if.vld), 64'h0);
            check("idle_err", 64'(rx_if.frm_err), 64'h0);
        end

        // 2: eight valid digits, publish on the eighth
        for (int i = 0; i < 8; i++) begin
            send_frame(8'hC0 + 8'(i), i);
            latch(i == 7, 1'b0, 1'b0, "t2");
            check("t2_dat", rx_if.dat, (i == 7) ? 64'hC7C6C5C4C3C2C1C0 : 64'h0);
        end

        // 3: 15-bit frame rejected, image held, following frames accepted
        send_bits({8'hEE, 8'h01}, 15);
        latch(1'b0, 1'b1, 1'b0, "t3_short");
        check("t3_dat_hold", rx_if.dat, 64'hC7C6C5C4C3C2C1C0);
        check("t3_state", 64'(state), 64'(RX_IDLE));
        for (int i = 0; i < 8; i++) begin
            send_frame(8'hA0 + 8'(i), i);
            latch(i == 7, 1'b0, 1'b0, "t3");
        end
        check("t3_dat", rx_if.dat, 64'hA7A6A5A4A3A2A1A0);

        // 4: two-hot select rejected and leaves the digit mask untouched
        send_bits({8'h99, 8'b0000_0011}, 16);
        latch(1'b0, 1'b1, 1'b0, "t4_bad_sel");
        for (int i = 1; i < 8; i++) begin
            send_frame(8'h50 + 8'(i), i);
            latch(1'b0, 1'b0, 1'b0, "t4");
        end
        check("t4_dat_hold", rx_if.dat, 64'hA7A6A5A4A3A2A1A0);
        send_frame(8'h50, 0);
        latch(1'b1, 1'b0, 1'b0, "t4_last");
        check("t4_dat", rx_if.dat, 64'h5756555453525150);

        // 5: loopback image with an overwritten digit and a same-cycle
        //    sclk/rclk edge on the final bit
        lb[0] = 8'hEF; lb[1] = 8'hCD; lb[2] = 8'hAB; lb[3] = 8'h89;
        lb[4] = 8'h67; lb[5] = 8'h45; lb[6] = 8'h23; lb[7] = 8'h01;
        send_frame(8'h00, 3);
        latch(1'b0, 1'b0, 1'b0, "t5_pre3");
        for (int i = 0; i < 7; i++) begin
            send_frame(lb[i], i);
            latch(1'b0, 1'b0, 1'b0, "t5");
        end
        send_bits({lb[7], 8'h80}, 15);
        rx_if.dio = 1'b0;
        repeat (2) @(negedge clk);
        latch(1'b1, 1'b0, 1'b1, "t5_same_edge");
        check("t5_dat", rx_if.dat, 64'h0123456789ABCDEF);

        // 6: partial frame left idle
        send_bits(16'hB5A5, 5);
        err_pulses = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rx_if.frm_err) err_pulses++;
            check("t6_no_vld", 64'(rx_if.vld), 64'h0);
        end
`ifdef LED7SEG_RX_TIMEOUT_EN
        check("t6_timeout_err", 64'(err_pulses), 64'd1);
        check("t6_state", 64'(state), 64'(RX_IDLE));
`else
        check("t6_no_timeout", 64'(err_pulses), 64'd0);
        check("t6_state", 64'(state), 64'(RX_SHIFT));
`endif
        latch(1'b0, 1'b1, 1'b0, "t6_rclk");
        check("t6_dat_hold", rx_if.dat, 64'h0123456789ABCDEF);

        // Final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
